// File: rtl/write_port_scheduler_pkg.sv
// -----------------------------------------------------------------------------
// write_port_scheduler_pkg
// Shared constants and FSM encoding for the SRAM write-port scheduler.
//   NUM_PORTS       number of requesting ingress ports
//   PRIO_W          width of each port's header priority field
//   SEL_W           width of the granted-port index (clog2 of NUM_PORTS)
//   TIMEOUT_CYCLES  grant cycles allowed before the watchdog forces a release
// -----------------------------------------------------------------------------
package write_port_scheduler_pkg;

  localparam int NUM_PORTS      = 16;
  localparam int PRIO_W         = 3;
  localparam int SEL_W          = 4;
  localparam int TIMEOUT_CYCLES = 1024;

  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_HOLD    = 2'd1;
  localparam logic [1:0] ST_RELEASE = 2'd2;

  typedef enum logic [1:0] {
    S_IDLE    = ST_IDLE,
    S_HOLD    = ST_HOLD,
    S_RELEASE = ST_RELEASE
  } sched_state_t;

endpackage : write_port_scheduler_pkg

// File: rtl/write_port_scheduler_picker.sv
// -----------------------------------------------------------------------------
// prio_rr_picker
// Combinational arbiter: highest priority among requesting ports wins; ties
// go to the first matching port found searching upward from i_rr_ptr+1
// (modulo num_of_ports).
//   i_ready     per-port request
//   i_priority  per-port priority, port i at [i*priority_width +: priority_width]
//   i_rr_ptr    last released port (search starts just after it)
//   o_winner    index of the selected port (0 when nothing requests)
//   o_max_p     highest requesting priority (0 when nothing requests)
//   o_any_req   at least one port is requesting
// -----------------------------------------------------------------------------
module prio_rr_picker
  import write_port_scheduler_pkg::*;
#(
  parameter int num_of_ports   = NUM_PORTS,
  parameter int priority_width = PRIO_W,
  parameter int sel_width      = SEL_W
) (
  input  logic [num_of_ports-1:0]                i_ready,
  input  logic [num_of_ports*priority_width-1:0] i_priority,
  input  logic [sel_width-1:0]                   i_rr_ptr,
  output logic [sel_width-1:0]                   o_winner,
  output logic [priority_width-1:0]              o_max_p,
  output logic                                   o_any_req
);

  logic [priority_width-1:0] w_max_p;
  logic [sel_width-1:0]      w_idx;
  logic                      w_found;

  // Pass 1: maximum priority over requesting ports only.
  always_comb begin
    // NOTE: every variable written here gets a default first, so no path
    // leaves it unassigned and no latch is inferred.
    w_max_p = '0;
    for (int i = 0; i < num_of_ports; i++) begin
      if (i_ready[i] && (i_priority[i*priority_width +: priority_width] > w_max_p)) begin
        w_max_p = i_priority[i*priority_width +: priority_width];
      end
    end
  end

  // Pass 2: rotating search from rr_ptr+1; k=num_of_ports revisits rr_ptr
  // itself last, so the previous owner only wins if nobody else ties.
  always_comb begin
    o_winner = '0;
    w_found  = 1'b0;
    w_idx    = '0;
    for (int k = 1; k <= num_of_ports; k++) begin
      w_idx = sel_width'((int'(i_rr_ptr) + k) % num_of_ports);
      if (!w_found && i_ready[w_idx] &&
          (i_priority[w_idx*priority_width +: priority_width] == w_max_p)) begin
        o_winner = w_idx;
        w_found  = 1'b1;
      end
    end
  end

  assign o_max_p   = w_max_p;
  assign o_any_req = |i_ready;

endmodule : prio_rr_picker

// File: rtl/write_port_scheduler.sv
// -----------------------------------------------------------------------------
// write_port_scheduler
// Grants the shared SRAM write path to one ingress port per packet. The grant
// is held until the owner's eop, or until the watchdog expires. Every release
// passes through RELEASE, so grant is low for at least one cycle between
// packets and never moves directly from one port to another.
//   clk, rst     clock, synchronous active-high reset
//   ready        per-port request (packet head available)
//   priority_in  per-port priority, port i at [i*priority_width +: priority_width]
//   eop          per-port end-of-packet beat (only the owner's is observed)
//   grant        one-hot grant (registered)
//   select       index of the granted port; keeps its value after release
//   grant_valid  high while a grant is held
//   grant_prio   priority latched at grant time
//   timeout_err  one-cycle pulse when the watchdog forces a release
// -----------------------------------------------------------------------------
module write_port_scheduler
  import write_port_scheduler_pkg::*;
#(
  parameter int num_of_ports   = NUM_PORTS,
  parameter int priority_width = PRIO_W,
  parameter int sel_width      = SEL_W,
  parameter int timeout_cycles = TIMEOUT_CYCLES
) (
  input  logic                                   clk,
  input  logic                                   rst,
  input  logic [num_of_ports-1:0]                ready,
  input  logic [num_of_ports*priority_width-1:0] priority_in,
  input  logic [num_of_ports-1:0]                eop,
  output logic [num_of_ports-1:0]                grant,
  output logic [sel_width-1:0]                   select,
  output logic                                   grant_valid,
  output logic [priority_width-1:0]              grant_prio,
  output logic                                   timeout_err
);

  localparam int                WD_W    = (timeout_cycles > 1) ? $clog2(timeout_cycles) : 1;
  localparam logic [WD_W-1:0]   WD_LAST = WD_W'(timeout_cycles - 1);
  localparam logic [num_of_ports-1:0] ONE_HOT_0 = {{(num_of_ports-1){1'b0}}, 1'b1};

  sched_state_t              r_state;
  logic [num_of_ports-1:0]   r_grant;
  logic [sel_width-1:0]      r_select;
  logic                      r_grant_valid;
  logic [priority_width-1:0] r_grant_prio;
  logic                      r_timeout_err;
  logic [sel_width-1:0]      r_rr_ptr;
  logic [WD_W-1:0]           r_wd;

  logic [sel_width-1:0]      w_winner;
  logic [priority_width-1:0] w_max_p;
  logic                      w_any_req;
  logic                      w_owner_eop;

  prio_rr_picker #(
    .num_of_ports   (num_of_ports),
    .priority_width (priority_width),
    .sel_width      (sel_width)
  ) u_picker (
    .i_ready    (ready),
    .i_priority (priority_in),
    .i_rr_ptr   (r_rr_ptr),
    .o_winner   (w_winner),
    .o_max_p    (w_max_p),
    .o_any_req  (w_any_req)
  );

  // Only the owner's eop matters; eop on other ports is ignored.
  assign w_owner_eop = eop[r_select];

  always_ff @(posedge clk) begin
    // NOTE: state is updated with non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    if (rst) begin
      r_state       <= S_IDLE;
      r_grant       <= '0;
      r_select      <= '0;
      r_grant_valid <= 1'b0;
      r_grant_prio  <= '0;
      r_timeout_err <= 1'b0;
      r_rr_ptr      <= sel_width'(num_of_ports - 1);
      r_wd          <= '0;
    end else begin
      r_timeout_err <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (w_any_req) begin
            r_grant       <= ONE_HOT_0 << w_winner;
            r_select      <= w_winner;
            r_grant_valid <= 1'b1;
            r_grant_prio  <= w_max_p;
            r_wd          <= '0;
            r_state       <= S_HOLD;
          end
        end
        S_HOLD: begin
          // eop is checked first so it wins over a simultaneous timeout.
          if (w_owner_eop) begin
            r_grant       <= '0;
            r_grant_valid <= 1'b0;
            r_rr_ptr      <= r_select;
            r_state       <= S_RELEASE;
          end else if (r_wd == WD_LAST) begin
            r_grant       <= '0;
            r_grant_valid <= 1'b0;
            r_rr_ptr      <= r_select;
            r_timeout_err <= 1'b1;
            r_state       <= S_RELEASE;
          end else if (r_wd != '1) begin
            r_wd <= r_wd + 1'b1;
          end
        end
        S_RELEASE: begin
          r_wd    <= '0;
          r_state <= S_IDLE;
        end
        default: begin
          r_grant       <= '0;
          r_grant_valid <= 1'b0;
          r_wd          <= '0;
          r_state       <= S_IDLE;
        end
      endcase
    end
  end

  assign grant       = r_grant;
  assign select      = r_select;
  assign grant_valid = r_grant_valid;
  assign grant_prio  = r_grant_prio;
  assign timeout_err = r_timeout_err;

endmodule : write_port_scheduler

// File: tb/tb_write_port_scheduler.sv
// -----------------------------------------------------------------------------
// tb_write_port_scheduler
// Directed stimulus pushes the expected (port, priority) of each upcoming
// grant into a queue; a monitor pops and compares on every new grant.
// Timing-sensitive properties (hold stability, gaps, watchdog, reset) are
// checked inline by the stimulus. The DUT runs with timeout_cycles=8.
// -----------------------------------------------------------------------------
module tb_write_port_scheduler;

  localparam int N  = 16;
  localparam int PW = 3;
  localparam int SW = 4;

  typedef struct {
    int port;
    int prio;
  } exp_grant_t;

  logic              clk = 1'b0;
  logic              rst;
  logic [N-1:0]      ready;
  logic [N*PW-1:0]   prio;
  logic [N-1:0]      eop;
  logic [N-1:0]      grant;
  logic [SW-1:0]     select;
  logic              grant_valid;
  logic [PW-1:0]     grant_prio;
  logic              timeout_err;

  exp_grant_t        exp_q[$];
  int                n_tests = 0;
  int                n_fail  = 0;
  logic              prev_valid = 1'b0;

  write_port_scheduler #(
    .num_of_ports   (N),
    .priority_width (PW),
    .sel_width      (SW),
    .timeout_cycles (8)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .ready       (ready),
    .priority_in (prio),
    .eop         (eop),
    .grant       (grant),
    .select      (select),
    .grant_valid (grant_valid),
    .grant_prio  (grant_prio),
    .timeout_err (timeout_err)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic set_prio(input int p, input int v);
    prio[p*PW +: PW] = PW'(v);
  endtask

  task automatic push_exp(input int p, input int v);
    exp_grant_t e;
    e.port = p;
    e.prio = v;
    exp_q.push_back(e);
  endtask

  // Called at the negedge of a HOLD cycle: eop on the owner, then both
  // zero-grant cycles (RELEASE, IDLE), ending where a new grant is visible.
  task automatic step_release(input int p, input logic [N-1:0] new_ready);
    eop   = N'(1) << p;
    ready = new_ready;
    tick(1);
    eop = '0;
    check("gap_release_valid", 32'(grant_valid), 32'd0);
    tick(1);
    check("gap_idle_valid", 32'(grant_valid), 32'd0);
    tick(1);
  endtask

  // Scoreboard monitor: compare each newly presented grant.
  initial begin
    forever begin
      @(negedge clk);
      if (grant_valid && !prev_valid) begin
        if (exp_q.size() == 0) begin
          check("unexpected_grant", 32'(grant), 32'd0);
        end else begin
          exp_grant_t e;
          e = exp_q.pop_front();
          check("sb_grant",  32'(grant),      32'(N'(1) << e.port));
          check("sb_select", 32'(select),     32'(e.port));
          check("sb_prio",   32'(grant_prio), 32'(e.prio));
        end
      end
      prev_valid = grant_valid;
    end
  end

  initial begin
    rst   = 1'b1;
    ready = '0;
    prio  = '0;
    eop   = '0;
    tick(2);
    check("rst_grant",       32'(grant),       32'd0);
    check("rst_select",      32'(select),      32'd0);
    check("rst_valid",       32'(grant_valid), 32'd0);
    check("rst_prio",        32'(grant_prio),  32'd0);
    check("rst_timeout_err", 32'(timeout_err), 32'd0);

    // Priority: port1 (5) beats port0 (2); port0 follows after release.
    rst = 1'b0;
    set_prio(0, 2);
    set_prio(1, 5);
    ready = 16'h0003;
    push_exp(1, 5);
    tick(1);
    check("prio_first_grant", 32'(grant), 32'h0002);
    push_exp(0, 2);
    step_release(1, 16'h0001);
    check("prio_second_grant", 32'(grant), 32'h0001);
    step_release(0, 16'h0000);

    // Tie at priority 3 between port0 and port15, starting from reset rr_ptr.
    rst = 1'b1;
    tick(1);
    rst = 1'b0;
    set_prio(0, 3);
    set_prio(15, 3);
    ready = 16'h8001;
    push_exp(0, 3);
    tick(1);
    check("tie_first", 32'(grant), 32'h0001);
    push_exp(15, 3);
    step_release(0, 16'h8001);
    check("tie_second", 32'(grant), 32'h8000);
    push_exp(0, 3);
    step_release(15, 16'h8001);
    check("tie_wrap", 32'(grant), 32'h0001);
    step_release(0, 16'h0000);

    // Hold: grant on port3 survives ready drop, foreign eop, new high prio.
    set_prio(3, 1);
    ready = 16'h0008;
    push_exp(3, 1);
    tick(1);
    ready = 16'h0080;
    eop   = 16'h0020;
    set_prio(7, 7);
    for (int i = 0; i < 3; i++) begin
      tick(1);
      check("hold_grant",  32'(grant),  32'h0008);
      check("hold_select", 32'(select), 32'd3);
    end
    eop = '0;
    push_exp(7, 7);
    step_release(3, 16'h0080);
    check("hold_next_grant", 32'(grant), 32'h0080);
    step_release(7, 16'h0000);

    // Single-beat packet on port2: grant one cycle wide, then re-arbitration.
    set_prio(2, 4);
    ready = 16'h0004;
    push_exp(2, 4);
    tick(1);
    check("single_grant", 32'(grant), 32'h0004);
    eop = 16'h0004;
    push_exp(2, 4);
    tick(1);
    check("single_width", 32'(grant_valid), 32'd0);
    eop = '0;
    tick(1);
    check("single_gap", 32'(grant_valid), 32'd0);
    tick(1);
    check("single_regrant", 32'(grant), 32'h0004);
    step_release(2, 16'h0000);

    // Watchdog: 8 HOLD cycles without eop, then forced release with a pulse.
    set_prio(4, 6);
    ready = 16'h0010;
    push_exp(4, 6);
    tick(1);
    ready = '0;
    for (int i = 1; i < 8; i++) begin
      tick(1);
      check("wd_hold_valid", 32'(grant_valid), 32'd1);
      check("wd_no_err",     32'(timeout_err), 32'd0);
    end
    tick(1);
    check("wd_release_valid", 32'(grant_valid), 32'd0);
    check("wd_err_pulse",     32'(timeout_err), 32'd1);
    tick(1);
    check("wd_err_one_cycle", 32'(timeout_err), 32'd0);

    // eop on the final watchdog cycle wins: no error pulse.
    ready = 16'h0010;
    push_exp(4, 6);
    tick(1);
    ready = '0;
    tick(7);
    check("wd_eop_still_held", 32'(grant_valid), 32'd1);
    eop = 16'h0010;
    tick(1);
    check("wd_eop_release", 32'(grant_valid), 32'd0);
    check("wd_eop_no_err",  32'(timeout_err), 32'd0);
    eop = '0;
    tick(1);
    check("wd_eop_no_err_late", 32'(timeout_err), 32'd0);

    // Reset mid-HOLD: outputs clear, rr_ptr returns to 15 so port0 wins.
    set_prio(5, 1);
    ready = 16'h0020;
    push_exp(5, 1);
    tick(2);
    rst   = 1'b1;
    ready = '0;
    tick(1);
    check("mid_rst_grant",  32'(grant),       32'd0);
    check("mid_rst_select", 32'(select),      32'd0);
    check("mid_rst_valid",  32'(grant_valid), 32'd0);
    check("mid_rst_prio",   32'(grant_prio),  32'd0);
    check("mid_rst_err",    32'(timeout_err), 32'd0);
    rst = 1'b0;
    for (int p = 0; p < N; p++) set_prio(p, 2);
    ready = 16'hFFFF;
    push_exp(0, 2);
    tick(1);
    check("post_rst_grant", 32'(grant), 32'h0001);
    step_release(0, 16'h0000);

    tick(3);
    check("sb_all_grants_seen", 32'(exp_q.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule : tb_write_port_scheduler
